// File: rtl/flow_stats_engine.sv
// Per-flow byte/packet statistics with a 3-stage read-modify-write update pipe
// and a 3-cycle host read path. An address forwarding network keeps both coherent.
module flow_stats_engine #(
    parameter int A_WIDTH       = 10,
    parameter int BCNT_W        = 32,
    parameter int PCNT_W        = 24,
    parameter int SATURATE      = 1,
    parameter int CLEAR_ON_READ = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [A_WIDTH-1:0] rx_flow_num_i,
    input  logic [15:0]        pkt_size_i,
    input  logic               pkt_size_en_i,
    input  logic               rd_stb_i,
    input  logic [A_WIDTH-1:0] rd_flow_num_i,
    output logic [BCNT_W-1:0]  rd_bytes_o,
    output logic [PCNT_W-1:0]  rd_pkts_o,
    output logic               rd_data_val_o,
    output logic               init_done_o
);

    localparam int DEPTH = 1 << A_WIDTH;
    localparam bit SAT   = (SATURATE != 0);
    localparam bit CLR   = (CLEAR_ON_READ != 0);

    typedef logic [A_WIDTH-1:0] flow_t;

    typedef struct packed {
        logic [BCNT_W-1:0] bytes;
        logic [PCNT_W-1:0] pkts;
    } cnt_t;

    function automatic cnt_t add_pkt(input cnt_t base, input logic [15:0] size);
        logic [BCNT_W:0] bsum;
        logic [PCNT_W:0] psum;
        cnt_t            res;
        bsum      = {1'b0, base.bytes} + {{(BCNT_W-15){1'b0}}, size};
        psum      = {1'b0, base.pkts} + {{PCNT_W{1'b0}}, 1'b1};
        res.bytes = (SAT && bsum[BCNT_W]) ? '1 : bsum[BCNT_W-1:0];
        res.pkts  = (SAT && psum[PCNT_W]) ? '1 : psum[PCNT_W-1:0];
        return res;
    endfunction

    // Newest first: this cycle's update write, this cycle's clear, then the
    // writes committed on the previous edge (which the RAM read did not see).
    function automatic cnt_t forward(
        input flow_t flow,       input cnt_t  ram_data,
        input logic  a_now,      input flow_t a_now_flow, input cnt_t a_now_data,
        input logic  b_now,      input flow_t b_now_flow,
        input logic  a_old,      input flow_t a_old_flow, input cnt_t a_old_data,
        input logic  b_old,      input flow_t b_old_flow
    );
        if (a_now && a_now_flow == flow)      return a_now_data;
        else if (b_now && b_now_flow == flow) return '0;
        else if (a_old && a_old_flow == flow) return a_old_data;
        else if (b_old && b_old_flow == flow) return '0;
        else                                  return ram_data;
    endfunction

    logic  init_done_q, init_done_d;
    flow_t init_addr_q, init_addr_d;

    logic        u1_vld_q, u1_vld_d, u2_vld_q, u2_vld_d, u3_vld_q, u3_vld_d;
    flow_t       u1_flow_q, u1_flow_d, u2_flow_q, u2_flow_d, u3_flow_q, u3_flow_d;
    logic [15:0] u1_size_q, u1_size_d, u2_size_q, u2_size_d, u3_size_q, u3_size_d;
    cnt_t        u3_base_q, u3_base_d;

    logic  r1_vld_q, r1_vld_d, r2_vld_q, r2_vld_d, r3_vld_q, r3_vld_d;
    flow_t r1_flow_q, r1_flow_d, r2_flow_q, r2_flow_d, r3_flow_q, r3_flow_d;

    logic  wa_vld_q, wa_vld_d, wb_vld_q, wb_vld_d;
    flow_t wa_flow_q, wa_flow_d, wb_flow_q, wb_flow_d;
    cnt_t  wa_data_q, wa_data_d;

    logic              rd_val_q, rd_val_d;
    logic [BCNT_W-1:0] rd_bytes_q, rd_bytes_d;
    logic [PCNT_W-1:0] rd_pkts_q, rd_pkts_d;

    logic  upd_acc, rd_acc, r3_clr, clr_we;
    cnt_t  u3_sum, u2_base, r2_res;
    logic  a_we, b_we;
    flow_t a_waddr, b_waddr;
    cnt_t  a_wdata;
    cnt_t  ram_a_rdata, ram_b_rdata;
    cnt_t  mem [DEPTH];

    // Port A serves the update read-modify-write, port B the host read/clear and the init sweep.
    always_ff @(posedge clk_i) begin
        // NOTE: the counter array is never reset; the init sweep zeroes it after every reset.
        if (a_we) mem[a_waddr] <= a_wdata;
        if (b_we) mem[b_waddr] <= '0;
        ram_a_rdata <= mem[u1_flow_q];
        ram_b_rdata <= mem[r1_flow_q];
    end

    always_comb begin
        // NOTE: every signal here is fully assigned on every pass, so no latch can be inferred.
        upd_acc = pkt_size_en_i && init_done_q;
        rd_acc  = rd_stb_i && init_done_q;
        u3_sum  = add_pkt(u3_base_q, u3_size_q);
        r3_clr  = r3_vld_q && CLR;
        // A same-cycle update to the cleared flow already carries the post-clear value.
        clr_we  = r3_clr && !(u3_vld_q && u3_flow_q == r3_flow_q);

        a_we    = u3_vld_q && !rst_i;
        a_waddr = u3_flow_q;
        a_wdata = u3_sum;
        b_we    = (!init_done_q || clr_we) && !rst_i;
        b_waddr = init_done_q ? r3_flow_q : init_addr_q;

        u2_base = forward(u2_flow_q, ram_a_rdata, u3_vld_q, u3_flow_q, u3_sum,
                          r3_clr, r3_flow_q, wa_vld_q, wa_flow_q, wa_data_q,
                          wb_vld_q, wb_flow_q);
        r2_res  = forward(r2_flow_q, ram_b_rdata, u3_vld_q, u3_flow_q, u3_sum,
                          r3_clr, r3_flow_q, wa_vld_q, wa_flow_q, wa_data_q,
                          wb_vld_q, wb_flow_q);

        init_addr_d = init_done_q ? init_addr_q : init_addr_q + 1'b1;
        init_done_d = init_done_q || (init_addr_q == '1);

        u1_vld_d  = upd_acc;
        u1_flow_d = rx_flow_num_i;
        u1_size_d = pkt_size_i;
        u2_vld_d  = u1_vld_q;
        u2_flow_d = u1_flow_q;
        u2_size_d = u1_size_q;
        u3_vld_d  = u2_vld_q;
        u3_flow_d = u2_flow_q;
        u3_size_d = u2_size_q;
        // An update accepted together with a clearing read of its flow starts from zero.
        u3_base_d = (r2_vld_q && CLR && r2_flow_q == u2_flow_q) ? '0 : u2_base;

        r1_vld_d  = rd_acc;
        r1_flow_d = rd_flow_num_i;
        r2_vld_d  = r1_vld_q;
        r2_flow_d = r1_flow_q;
        r3_vld_d  = r2_vld_q;
        r3_flow_d = r2_flow_q;

        wa_vld_d  = u3_vld_q;
        wa_flow_d = u3_flow_q;
        wa_data_d = u3_sum;
        wb_vld_d  = clr_we;
        wb_flow_d = r3_flow_q;

        rd_val_d   = r2_vld_q;
        rd_bytes_d = r2_vld_q ? r2_res.bytes : rd_bytes_q;
        rd_pkts_d  = r2_vld_q ? r2_res.pkts : rd_pkts_q;
    end

    // Control state and outputs.
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments so every stage samples its neighbour's pre-edge value.
        if (rst_i) begin
            init_done_q <= 1'b0;
            init_addr_q <= '0;
            u1_vld_q    <= 1'b0;
            u2_vld_q    <= 1'b0;
            u3_vld_q    <= 1'b0;
            r1_vld_q    <= 1'b0;
            r2_vld_q    <= 1'b0;
            r3_vld_q    <= 1'b0;
            wa_vld_q    <= 1'b0;
            wb_vld_q    <= 1'b0;
            rd_val_q    <= 1'b0;
            rd_bytes_q  <= '0;
            rd_pkts_q   <= '0;
        end else begin
            init_done_q <= init_done_d;
            init_addr_q <= init_addr_d;
            u1_vld_q    <= u1_vld_d;
            u2_vld_q    <= u2_vld_d;
            u3_vld_q    <= u3_vld_d;
            r1_vld_q    <= r1_vld_d;
            r2_vld_q    <= r2_vld_d;
            r3_vld_q    <= r3_vld_d;
            wa_vld_q    <= wa_vld_d;
            wb_vld_q    <= wb_vld_d;
            rd_val_q    <= rd_val_d;
            rd_bytes_q  <= rd_bytes_d;
            rd_pkts_q   <= rd_pkts_d;
        end
    end

    // Datapath payload is qualified by the valids above and needs no reset.
    always_ff @(posedge clk_i) begin
        u1_flow_q <= u1_flow_d;
        u1_size_q <= u1_size_d;
        u2_flow_q <= u2_flow_d;
        u2_size_q <= u2_size_d;
        u3_flow_q <= u3_flow_d;
        u3_size_q <= u3_size_d;
        u3_base_q <= u3_base_d;
        r1_flow_q <= r1_flow_d;
        r2_flow_q <= r2_flow_d;
        r3_flow_q <= r3_flow_d;
        wa_flow_q <= wa_flow_d;
        wa_data_q <= wa_data_d;
        wb_flow_q <= wb_flow_d;
    end

    assign rd_bytes_o    = rd_bytes_q;
    assign rd_pkts_o     = rd_pkts_q;
    assign rd_data_val_o = rd_val_q;
    assign init_done_o   = init_done_q;

endmodule

// File: doc/flow_stats_engine.md
Name: flow_stats_engine

Overview:
- Per-flow traffic statistics block. Keeps a byte counter and a packet counter for each of 2**A_WIDTH flows, held in on-chip RAM.
- Accepts one packet-size update per cycle and one host read per cycle. Both can arrive in the same cycle.
- Read mode is selectable: read-and-clear, or read-only.
- Sits between the packet parser (size/flow stream) and the host statistics interface.

Parameters:
- A_WIDTH, 10, flow-number width; 2**A_WIDTH flows.
- BCNT_W, 32, byte-counter width (must be >= 16).
- PCNT_W, 24, packet-counter width.
- SATURATE, 1, 1 = counters stick at all-ones; 0 = counters wrap modulo 2**width.
- CLEAR_ON_READ, 1, 1 = a read zeroes the flow's counters; 0 = a read leaves them unchanged.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- rx_flow_num_i  in  A_WIDTH  flow of the update.
- pkt_size_i  in  16  packet size in bytes.
- pkt_size_en_i  in  1  update valid.
- rd_stb_i  in  1  read request, single-cycle strobe.
- rd_flow_num_i  in  A_WIDTH  flow to read.
- rd_bytes_o  out  BCNT_W  byte count of the read flow.
- rd_pkts_o  out  PCNT_W  packet count of the read flow.
- rd_data_val_o  out  1  read result valid, one-cycle pulse.
- init_done_o  out  1  counter RAM cleared; inputs are accepted.

Behaviour:
- Reset:
  - While rst_i is high, all outputs are 0, all pipeline valids are cleared, and in-flight updates and reads are discarded.
  - Reset asserted mid-operation aborts everything and restarts the init sweep.
- Init sweep:
  - Starts in the cycle after rst_i deasserts.
  - Writes zero to addresses 0 .. 2**A_WIDTH-1, one address per cycle.
  - init_done_o goes high in the cycle after the last address is written and then stays high until the next reset.
  - While init_done_o is low, pkt_size_en_i and rd_stb_i are ignored: no update is applied and no rd_data_val_o is produced.
- Update path (3-stage read-modify-write):
  - S1: register flow, size and valid; issue RAM read.
  - S2: RAM data returns; apply forwarding.
  - S3: add pkt_size (zero-extended) to the byte counter and 1 to the packet counter; write both back.
- Throughput: one update per cycle, sustained, with no stalls and no dropped updates.
- Forwarding for the update path:
  - Any update to the same flow that is still in S2/S3 or being written this cycle must be forwarded.
  - Example: back-to-back updates to flow F with sizes a, b, c give final bytes = a+b+c and pkts = 3, never a lost increment.
- Read path:
  - rd_stb_i accepted in cycle N gives rd_data_val_o high in cycle N+3, with rd_bytes_o/rd_pkts_o valid in that cycle.
  - rd_bytes_o/rd_pkts_o hold their last value when rd_data_val_o is low.
- Ordering:
  - A read returns the counters including every update accepted in earlier cycles, using forwarding from the update pipeline.
  - An update accepted in the same cycle as a read to the same flow is NOT included in the read result. With CLEAR_ON_READ=1 it becomes the first contribution after the clear.
- Clear-on-read (CLEAR_ON_READ=1):
  - The read writes zero to the flow in its S3 slot.
  - Updates to that flow already in flight are accounted to the read; later updates start from zero.
  - Reads and writes to different flows are independent.
- Arithmetic:
  - SATURATE=1: byte sum is clamped to 2**BCNT_W-1 and packet count to 2**PCNT_W-1. Each counter saturates independently.
  - SATURATE=0: both counters wrap.
- RAM: a single true-dual-port RAM, one port for update RMW and one for read/clear. Same-address conflicts are resolved only by forwarding logic, never by RAM read-during-write behaviour.

Test Plan:
- Init: A_WIDTH=4. Deassert reset at cycle 0 → init_done_o rises at cycle 16 or 17 (fixed, documented). A rd_stb_i asserted during the sweep produces no rd_data_val_o. After init, a read of any flow returns 0/0.
- Accumulate: sizes 1..6 to flows 1..6, then sizes 10, 20, 30 back-to-back to flow 3, then read flow 3 → rd_bytes_o=63, rd_pkts_o=4, 3 cycles after the strobe.
- Read-and-clear collision: update flow 2 +100, then in the next cycle read flow 2 together with a same-cycle update flow 2 +7 → read returns 100/1. A second read returns 7/1. A third read returns 0/0.
- Read-only mode: CLEAR_ON_READ=0. Updates +5, +5 to flow 9, read twice → both reads return 10/2.
- Saturation: BCNT_W=16, SATURATE=1. Updates 40000 and 40000 to flow 1 → bytes=65535, pkts=2. With SATURATE=0 → bytes=14464.
- Reset mid-traffic: continuous updates and reads, assert rst_i for one cycle → outputs 0, rd_data_val_o stays low until after the new init sweep, and every flow then reads 0/0.
